// File: rtl/i2c_sched.sv
// Arbiter for the shared I2C engine: codec init first, then round-robin between
// the four requesters, with a watchdog that aborts a stuck engine transaction.
module i2c_sched #(
   parameter int TIMEOUT = 65535
) (
   input  logic       clk_256fs,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       eng_start,
   input  logic       eng_done,
   input  logic       eng_nack,
   output logic       eng_abort,
   output logic [3:0] done,
   output logic       nack,
   output logic       timeout_err,
   output logic       init_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [3:0]  grant_nxt, done_nxt;
   logic [1:0]  sel_nxt;
   logic [1:0]  last, last_nxt;
   logic [15:0] timer, timer_nxt;
   logic        eng_start_nxt, eng_abort_nxt, nack_nxt, timeout_err_nxt, init_done_nxt;
   logic [3:0]  cand;
   logic [2:0]  win;

   // Returns {found, index}; the requester right after last_idx has top priority.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last_idx);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = last_idx + 2'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Until the codec is initialised only requester 0 may compete.
   assign cand = init_done ? req : {3'b000, req[0]};
   assign win  = rr_pick(cand, last);

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      sel_nxt         = sel;
      last_nxt        = last;
      timer_nxt       = timer;
      init_done_nxt   = init_done;
      eng_start_nxt   = 1'b0;
      eng_abort_nxt   = 1'b0;
      done_nxt        = 4'b0000;
      nack_nxt        = 1'b0;
      timeout_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (win[2]) begin
               grant_nxt = 4'b0001 << win[1:0];
               sel_nxt   = win[1:0];
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            eng_start_nxt = 1'b1;
            timer_nxt     = 16'd0;
            state_nxt     = WAIT;
         end
         WAIT: begin
            // A completion arriving on the last timer count beats the watchdog.
            if (eng_done) begin
               done_nxt  = grant;
               nack_nxt  = eng_nack;
               state_nxt = RELEASE;
            end else if (timer == TIMER_LAST) begin
               done_nxt        = grant;
               nack_nxt        = 1'b1;
               eng_abort_nxt   = 1'b1;
               timeout_err_nxt = 1'b1;
               state_nxt       = RELEASE;
            end else begin
               timer_nxt = timer + 16'd1;
            end
         end
         RELEASE: begin
            grant_nxt = 4'b0000;
            sel_nxt   = 2'd0;
            last_nxt  = sel;
            if (done[0] && !nack) init_done_nxt = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_256fs) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= 4'b0000;
         sel         <= 2'd0;
         last        <= 2'd3;
         timer       <= 16'd0;
         init_done   <= 1'b0;
         eng_start   <= 1'b0;
         eng_abort   <= 1'b0;
         done        <= 4'b0000;
         nack        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         sel         <= sel_nxt;
         last        <= last_nxt;
         timer       <= timer_nxt;
         init_done   <= init_done_nxt;
         eng_start   <= eng_start_nxt;
         eng_abort   <= eng_abort_nxt;
         done        <= done_nxt;
         nack        <= nack_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

endmodule

// File: tb/tb_i2c_sched.sv
// Bench for i2c_sched: two instances (default and short watchdog) driven in
// parallel and compared every cycle against a transaction-level model.
module tb_i2c_sched;

   logic       clk_256fs = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       eng_done = 1'b0;
   logic       eng_nack = 1'b0;

   logic [3:0] grant_l, done_l, grant_s, done_s;
   logic [1:0] sel_l, sel_s;
   logic       eng_start_l, eng_abort_l, nack_l, timeout_err_l, init_done_l;
   logic       eng_start_s, eng_abort_s, nack_s, timeout_err_s, init_done_s;
   logic [14:0] obs_l, obs_s;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   always #5 clk_256fs = ~clk_256fs;

   i2c_sched u_long (
      .clk_256fs(clk_256fs), .rst(rst), .req(req), .grant(grant_l), .sel(sel_l),
      .eng_start(eng_start_l), .eng_done(eng_done), .eng_nack(eng_nack),
      .eng_abort(eng_abort_l), .done(done_l), .nack(nack_l),
      .timeout_err(timeout_err_l), .init_done(init_done_l)
   );

   i2c_sched #(.TIMEOUT(16)) u_short (
      .clk_256fs(clk_256fs), .rst(rst), .req(req), .grant(grant_s), .sel(sel_s),
      .eng_start(eng_start_s), .eng_done(eng_done), .eng_nack(eng_nack),
      .eng_abort(eng_abort_s), .done(done_s), .nack(nack_s),
      .timeout_err(timeout_err_s), .init_done(init_done_s)
   );

   assign obs_l = {grant_l, sel_l, eng_start_l, eng_abort_l, done_l, nack_l, timeout_err_l, init_done_l};
   assign obs_s = {grant_s, sel_s, eng_start_s, eng_abort_s, done_s, nack_s, timeout_err_s, init_done_s};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: cnt counts cycles since the grant became visible; dcyc is the cycle
   // on which done is due once the outcome is known (0 = still waiting).
   typedef struct {
      bit active;
      int owner;
      int cnt;
      int dcyc;
      bit dnack;
      bit dto;
      int last;
      bit init;
   } mdl_t;

   mdl_t m_l, m_s;

   function automatic mdl_t m_next(input mdl_t s, input int to, input logic r,
                                   input logic [3:0] rq, input logic ed, input logic en);
      logic [3:0] cand;
      int idx;
      bit found;
      if (r) begin
         s.active = 0; s.owner = 0; s.cnt = 0; s.dcyc = 0;
         s.dnack = 0; s.dto = 0; s.last = 3; s.init = 0;
      end else if (!s.active) begin
         cand = s.init ? rq : (rq & 4'b0001);
         found = 0;
         for (int i = 1; i <= 4; i++) begin
            idx = (s.last + i) % 4;
            if (!found && cand[idx]) begin
               found = 1; s.active = 1; s.owner = idx; s.cnt = 0; s.dcyc = 0;
            end
         end
      end else if (s.dcyc != 0 && s.cnt == s.dcyc) begin
         s.active = 0;
         s.last = s.owner;
         if (s.owner == 0 && !s.dnack) s.init = 1;
      end else begin
         if (s.cnt >= 1 && s.dcyc == 0) begin
            if (ed) begin
               s.dcyc = s.cnt + 1; s.dnack = en; s.dto = 0;
            end else if (s.cnt == to) begin
               s.dcyc = s.cnt + 1; s.dnack = 1; s.dto = 1;
            end
         end
         s.cnt++;
      end
      return s;
   endfunction

   function automatic logic [14:0] m_out(input mdl_t s);
      logic [3:0] g, d;
      logic [1:0] sl;
      logic st, ab, nk, tt;
      g = 0; d = 0; sl = 0; st = 0; ab = 0; nk = 0; tt = 0;
      if (s.active) begin
         g  = 4'(1 << s.owner);
         sl = 2'(s.owner);
         st = (s.cnt == 1);
         if (s.dcyc != 0 && s.cnt == s.dcyc) begin
            d = g; nk = s.dnack; ab = s.dto; tt = s.dto;
         end
      end
      return {g, sl, st, ab, d, nk, tt, s.init};
   endfunction

   always @(posedge clk_256fs) begin
      m_l <= m_next(m_l, 65535, rst, req, eng_done, eng_nack);
      m_s <= m_next(m_s, 16, rst, req, eng_done, eng_nack);
   end

   always @(negedge clk_256fs) begin
      if (chk_on) begin
         chk("cyc_long", 32'(obs_l), 32'(m_out(m_l)));
         chk("cyc_short", 32'(obs_s), 32'(m_out(m_s)));
      end
   end

   task automatic step();
      @(posedge clk_256fs);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

   logic [3:0] seen_g;
   logic [1:0] seen_st;
   logic [3:0] exp_seq [6];
   int n, k, z;

   initial begin
      exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
      repeat (3) step();
      chk("rst_long", 32'(obs_l), 32'd0);
      chk("rst_short", 32'(obs_s), 32'd0);
      chk_on = 1'b1;
      rst = 1'b0;

      // Other requesters are locked out before init.
      req = 4'b1110;
      seen_g = 0; seen_st = 0;
      repeat (100) begin
         step();
         seen_g |= grant_l | grant_s;
         seen_st |= {eng_start_l, eng_start_s};
      end
      chk("s1_grant", 32'(seen_g), 32'd0);
      chk("s1_start", 32'(seen_st), 32'd0);

      // Codec init transaction, completed 50 cycles after start.
      req = 4'b0001;
      n = 0;
      do begin step(); n++; end while (!eng_start_l && n < 10);
      chk("s2_latency", n, 2);
      chk("s2_grant", 32'(grant_l), 32'd1);
      req = 4'b0000;
      repeat (50) step();
      eng_done = 1'b1; eng_nack = 1'b0;
      step();
      eng_done = 1'b0;
      chk("s2_done", 32'(done_l), 32'd1);
      chk("s2_nack", 32'(nack_l), 32'd0);
      chk("s2_init_pre", 32'(init_done_l), 32'd0);
      step();
      chk("s2_init", 32'(init_done_l), 32'd1);
      chk("s2_gclr", 32'(grant_l), 32'd0);

      // Round-robin among requesters 1..3.
      req = 4'b1110;
      for (int i = 0; i < 6; i++) begin
         z = 0; n = 0;
         do begin
            step();
            if (grant_l == 4'b0000) z++;
            n++;
         end while (grant_l == 4'b0000 && n < 10);
         if (i > 0) chk("s3_gap", z, 1);
         chk("s3_grant", 32'(grant_l), 32'(exp_seq[i]));
         repeat (3) step();
         if (i == 5) req = 4'b0000;
         eng_done = 1'b1;
         step();
         eng_done = 1'b0;
      end
      step();

      // Watchdog expiry on the short instance.
      req = 4'b0001;
      n = 0;
      do begin step(); n++; end while (!eng_start_s && n < 10);
      chk("s4_start", 32'(eng_start_s), 32'd1);
      req = 4'b0000;
      k = 0;
      do begin step(); k++; end while (!eng_abort_s && k < 40);
      chk("s4_when", k, 16);
      chk("s4_tout", 32'(timeout_err_s), 32'd1);
      chk("s4_done", 32'(done_s), 32'd1);
      chk("s4_nack", 32'(nack_s), 32'd1);
      chk("s4_ghold", 32'(grant_s), 32'd1);
      step();
      chk("s4_gclr", 32'(grant_s), 32'd0);

      // Completion on the final watchdog count wins.
      req = 4'b0001;
      n = 0;
      do begin step(); n++; end while (!eng_start_s && n < 10);
      req = 4'b0000;
      repeat (15) step();
      eng_done = 1'b1; eng_nack = 1'b0;
      step();
      eng_done = 1'b0;
      chk("s5_done", 32'(done_s), 32'd1);
      chk("s5_nack", 32'(nack_s), 32'd0);
      chk("s5_abort", 32'(eng_abort_s), 32'd0);
      chk("s5_tout", 32'(timeout_err_s), 32'd0);

      // Reset in the middle of a transaction.
      step();
      rst = 1'b1; step(); rst = 1'b0;
      req = 4'b0001;
      n = 0;
      do begin step(); n++; end while (!eng_start_l && n < 10);
      chk("s6_start", 32'(eng_start_l), 32'd1);
      repeat (3) step();
      rst = 1'b1;
      step();
      chk("s6_rst_long", 32'(obs_l), 32'd0);
      chk("s6_rst_short", 32'(obs_s), 32'd0);
      rst = 1'b0;
      req = 4'b0010;
      seen_g = 0;
      repeat (30) begin step(); seen_g |= grant_l; end
      chk("s6_ignore", 32'(seen_g), 32'd0);
      req = 4'b0011;
      n = 0;
      do begin step(); n++; end while (grant_l == 4'b0000 && n < 10);
      chk("s6_g0", 32'(grant_l), 32'd1);
      repeat (3) step();
      eng_done = 1'b1; eng_nack = 1'b0;
      step();
      eng_done = 1'b0;
      n = 0;
      do begin step(); n++; end while (grant_l != 4'b0010 && n < 10);
      chk("s6_g1", 32'(grant_l), 32'd2);
      req = 4'b0000;
      repeat (3) step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      repeat (3) step();

      // Random traffic, checked cycle by cycle against the model.
      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         eng_done = ($urandom_range(0, 11) == 0);
         eng_nack = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 599) == 0);
         step();
      end
      rst = 1'b0; eng_done = 1'b0; req = 4'b0000;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_sched.md
I2C_SCHED -- requirements
Module: i2c_sched

Interface
- REQ-001: The module SHALL have parameter TIMEOUT, default 65535; maximum engine cycles per transaction, 16-bit, must be ≥2.
- REQ-002: The module SHALL have port clk_256fs, input, 1 bit; the system clock; all logic is on its rising edge.
- REQ-003: The module SHALL have port rst, input, 1 bit; synchronous, active-high reset.
- REQ-004: The module SHALL have port req, input, 4 bits; level request per requester: 0 = codec init, 1 = EEPROM, 2 = jack poll, 3 = touch poll.
- REQ-005: The module SHALL have port grant, output, 4 bits; one-hot (or zero) owner of the I2C engine.
- REQ-006: The module SHALL have port sel, output, 2 bits; binary index of the granted requester, for the command mux.
- REQ-007: The module SHALL have port eng_start, output, 1 bit; one-cycle pulse that launches the shared I2C engine.
- REQ-008: The module SHALL have port eng_done, input, 1 bit; one-cycle pulse when the engine finishes a transaction.
- REQ-009: The module SHALL have port eng_nack, input, 1 bit; NACK status, valid only with eng_done.
- REQ-010: The module SHALL have port eng_abort, output, 1 bit; one-cycle pulse that forces the engine to idle and release the bus.
- REQ-011: The module SHALL have port done, output, 4 bits; one-cycle completion pulse to the owning requester.
- REQ-012: The module SHALL have port nack, output, 1 bit; valid with done; 1 = NACK or timeout.
- REQ-013: The module SHALL have port timeout_err, output, 1 bit; one-cycle pulse on watchdog expiry.
- REQ-014: The module SHALL have port init_done, output, 1 bit; sticky; set when requester 0 completes a transaction with nack=0.

Function
- REQ-015: The module SHALL implement an FSM with states IDLE, ISSUE, WAIT, RELEASE; every transition occurs on a clk_256fs edge.
- REQ-016: In IDLE with init_done=0, the module SHALL consider only req[0]; req[3:1] are ignored until init completes.
- REQ-017: In IDLE with init_done=1, the module SHALL arbitrate round-robin, searching from (last+1) mod 4, where last is the previously granted index (reset value 3, so requester 0 wins first).
- REQ-018: On a winning request in IDLE, the module SHALL register grant/sel on the next edge and go to ISSUE; with no request it SHALL stay in IDLE with grant=0.
- REQ-019: In ISSUE, the module SHALL assert eng_start for exactly one cycle, clear the timer, and go to WAIT; latency from req sampled high in IDLE to eng_start high SHALL be 2 cycles.
- REQ-020: In WAIT, the timer SHALL increment by 1 per cycle.
- REQ-021: In WAIT, on eng_done the module SHALL pulse done[sel], set nack=eng_nack that same cycle, and go to RELEASE.
- REQ-022: In WAIT, if the timer reaches TIMEOUT-1 without eng_done, the module SHALL pulse eng_abort, timeout_err and done[sel] with nack=1, then go to RELEASE.
- REQ-023: If eng_done coincides with the timer reaching TIMEOUT-1, the module SHALL treat it as normal completion: done wins, with no abort and no timeout_err.
- REQ-024: In RELEASE, the module SHALL clear grant and sel, update last with the released index, and return to IDLE; this gives a one-cycle bus-free gap between transactions.
- REQ-025: On done[0] with nack=0, the module SHALL set init_done to 1; a NACK or timeout on requester 0 SHALL leave init_done at 0, and requester 0 is re-arbitrated.
- REQ-026: The module SHALL ignore eng_done and eng_nack in IDLE, ISSUE and RELEASE.
- REQ-027: If req[sel] drops during WAIT, the transaction SHALL still complete and done SHALL still pulse.
- REQ-028: A requester whose req is still high after its done SHALL be re-arbitrated normally and SHALL NOT win twice consecutively while others are requesting.
- REQ-029: grant SHALL be constant from ISSUE through the done cycle.
- REQ-030: At most one bit of grant and of done SHALL be set at any time.

Reset
- REQ-031: While rst=1, the module SHALL be in IDLE with grant=0, sel=0, eng_start=0, eng_abort=0, done=0, nack=0, timeout_err=0, init_done=0, timer=0, last=3.
- REQ-032: Reset asserted mid-transaction SHALL take effect on the next edge with no abort pulse; the engine is reset by the same rst.

Verification
- REQ-033: The bench SHALL cover: rst released, req=4'b1110 for 100 cycles -> grant stays 0, eng_start never pulses.
- REQ-034: The bench SHALL cover: req=4'b0001, eng_done 50 cycles after eng_start with eng_nack=0 -> eng_start exactly 2 cycles after req; done=4'b0001, nack=0; init_done=1 from the next cycle.
- REQ-035: The bench SHALL cover: init done, req=4'b1110 held, each transaction completed -> grant order 2,4,8,2,4,8 with a 1-cycle zero-grant gap between each.
- REQ-036: The bench SHALL cover: TIMEOUT=16, no eng_done -> eng_abort, timeout_err and done[sel] with nack=1 all on the 16th cycle after eng_start; grant clears one cycle later.
- REQ-037: The bench SHALL cover: TIMEOUT=16, eng_done on the 16th cycle -> done with nack=eng_nack; no eng_abort, no timeout_err.
- REQ-038: The bench SHALL cover: rst pulsed while in WAIT -> all outputs zero on the next edge; a subsequent req=4'b0010 is ignored until requester 0 completes.
